// File: rtl/pipe_collision_detector.sv
// Per-frame bird/pipe collision checker running on the system clock.
// A frame-clock rising edge starts a scan. The scan snapshots all coordinates,
// checks the floor and the ceiling, then tests one pipe per cycle. The first
// hit is latched into sticky outputs until the game returns to the start screen.
module pipe_collision_detector #(
  parameter int NUM_PIPES   = 4,
  parameter int PIPE_SIZE_X = 78,
  parameter int GAP_H       = 128,
  parameter int BIRD_W      = 34,
  parameter int BIRD_H      = 24,
  parameter int PLAY_H      = 420
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        FL_clk,
  input  logic [3:0]  game_state,
  input  logic [31:0] birdX,
  input  logic [31:0] birdY,
  input  logic [31:0] pipeX_1,
  input  logic [31:0] pipeX_2,
  input  logic [31:0] pipeX_3,
  input  logic [31:0] pipeX_4,
  input  logic [31:0] pipeY_1,
  input  logic [31:0] pipeY_2,
  input  logic [31:0] pipeY_3,
  input  logic [31:0] pipeY_4,
  output logic        collision,
  output logic        hit_pulse,
  output logic [1:0]  hit_type,
  output logic [1:0]  hit_pipe,
  output logic        check_done
);

  localparam logic [3:0] GS_START  = 4'b0001;
  localparam logic [3:0] GS_INGAME = 4'b0010;

  localparam logic [1:0] LAST_IDX = 2'(NUM_PIPES - 1);

  localparam logic signed [32:0] BIRD_W_S = 33'(BIRD_W);
  localparam logic signed [32:0] BIRD_H_S = 33'(BIRD_H);
  localparam logic signed [32:0] PIPE_W_S = 33'(PIPE_SIZE_X);
  localparam logic signed [32:0] GAP_H_S  = 33'(GAP_H);
  localparam logic signed [32:0] PLAY_H_S = 33'(PLAY_H);

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    BOUNDS,
    SCAN,
    REPORT
  } stateT;

  stateT state, nextState;

  logic sync1, sync2, sync3, frameTick;
  logic inGame, startScreen;

  logic [31:0] snapBirdX, snapBirdY;
  logic [31:0] snapPipeX [4];
  logic [31:0] snapPipeY [4];
  logic [1:0]  idx;

  logic        foundAcc;
  logic [1:0]  typeAcc, pipeAcc;

  logic signed [32:0] bx, by, px, py;
  logic        floorHit, ceilHit, xOverlap, pipeHit;
  logic        scanFound;
  logic [1:0]  scanType, scanPipe;

  assign inGame      = (game_state == GS_INGAME);
  assign startScreen = (game_state == GS_START);

  // Frame clock synchroniser and rising-edge detect (registered tick)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      frameTick <= 1'b0;
    end else begin
      sync1     <= FL_clk;
      sync2     <= sync1;
      sync3     <= sync2;
      frameTick <= sync2 & ~sync3;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic: start screen forces idle, leaving IN_GAME aborts a scan
  always_comb begin
    nextState = state;
    if (startScreen) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (frameTick && inGame) nextState = SNAP;
        SNAP:    nextState = inGame ? BOUNDS : IDLE;
        BOUNDS:  nextState = inGame ? SCAN : IDLE;
        SCAN: begin
          if (!inGame)              nextState = IDLE;
          else if (idx == LAST_IDX) nextState = REPORT;
        end
        REPORT:  nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // Hit tests on snapshot data, sign-extended to 33 bits so sums cannot wrap
  always_comb begin
    bx = {snapBirdX[31], snapBirdX};
    by = {snapBirdY[31], snapBirdY};
    px = {snapPipeX[idx][31], snapPipeX[idx]};
    py = {snapPipeY[idx][31], snapPipeY[idx]};
    floorHit = (by + BIRD_H_S) >= PLAY_H_S;
    ceilHit  = snapBirdY[31];
    xOverlap = ((bx + BIRD_W_S) > px) && (bx < (px + PIPE_W_S));
    pipeHit  = xOverlap && ((by < py) || ((by + BIRD_H_S) > (py + GAP_H_S)));
    scanFound = foundAcc;
    scanType  = typeAcc;
    scanPipe  = pipeAcc;
    if (!foundAcc && pipeHit) begin
      scanFound = 1'b1;
      scanType  = 2'b01;
      scanPipe  = idx;
    end
  end

  // Snapshot capture, first-hit accumulation and sticky result outputs.
  // Results load on the edge into REPORT, so they are visible during REPORT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snapBirdX  <= '0;
      snapBirdY  <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        snapPipeX[i] <= '0;
        snapPipeY[i] <= '0;
      end
      idx        <= '0;
      foundAcc   <= 1'b0;
      typeAcc    <= '0;
      pipeAcc    <= '0;
      collision  <= 1'b0;
      hit_pulse  <= 1'b0;
      hit_type   <= '0;
      hit_pipe   <= '0;
      check_done <= 1'b0;
    end else begin
      hit_pulse  <= 1'b0;
      check_done <= 1'b0;
      case (state)
        SNAP: begin
          snapBirdX    <= birdX;
          snapBirdY    <= birdY;
          snapPipeX[0] <= pipeX_1;
          snapPipeX[1] <= pipeX_2;
          snapPipeX[2] <= pipeX_3;
          snapPipeX[3] <= pipeX_4;
          snapPipeY[0] <= pipeY_1;
          snapPipeY[1] <= pipeY_2;
          snapPipeY[2] <= pipeY_3;
          snapPipeY[3] <= pipeY_4;
          idx          <= '0;
          foundAcc     <= 1'b0;
          typeAcc      <= '0;
          pipeAcc      <= '0;
        end
        BOUNDS: begin
          if (floorHit) begin
            foundAcc <= 1'b1;
            typeAcc  <= 2'b10;
          end else if (ceilHit) begin
            foundAcc <= 1'b1;
            typeAcc  <= 2'b11;
          end
        end
        SCAN: begin
          foundAcc <= scanFound;
          typeAcc  <= scanType;
          pipeAcc  <= scanPipe;
          idx      <= idx + 2'd1;
        end
        default: ;
      endcase

      if (startScreen) begin
        collision <= 1'b0;
        hit_type  <= '0;
        hit_pipe  <= '0;
      end else if (state == SCAN && nextState == REPORT) begin
        check_done <= 1'b1;
        if (!collision && scanFound) begin
          collision <= 1'b1;
          hit_pulse <= 1'b1;
          hit_type  <= scanType;
          hit_pipe  <= scanPipe;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_collision_detector.sv
// Randomized and directed bench for pipe_collision_detector with a
// geometry-level reference model of the first-hit and sticky-result rules.
module tb_pipe_collision_detector;

  localparam logic [3:0] GS_START = 4'b0001;
  localparam logic [3:0] GS_IN    = 4'b0010;
  localparam logic [3:0] GS_PAUSE = 4'b0100;
  localparam logic [3:0] GS_END   = 4'b1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        FL_clk;
  logic [3:0]  game_state;
  logic [31:0] birdX, birdY;
  logic [31:0] pipeX_1, pipeX_2, pipeX_3, pipeX_4;
  logic [31:0] pipeY_1, pipeY_2, pipeY_3, pipeY_4;
  logic        collision, hit_pulse, check_done;
  logic [1:0]  hit_type, hit_pipe;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: scenario coordinates and sticky result
  int         mBX, mBY;
  int         mPX [4];
  int         mPY [4];
  bit         mCol;
  logic [1:0] mType, mPipe;

  pipe_collision_detector #(
    .NUM_PIPES(4), .PIPE_SIZE_X(78), .GAP_H(128),
    .BIRD_W(34), .BIRD_H(24), .PLAY_H(420)
  ) dut (
    .clk(clk), .rst(rst), .FL_clk(FL_clk), .game_state(game_state),
    .birdX(birdX), .birdY(birdY),
    .pipeX_1(pipeX_1), .pipeX_2(pipeX_2), .pipeX_3(pipeX_3), .pipeX_4(pipeX_4),
    .pipeY_1(pipeY_1), .pipeY_2(pipeY_2), .pipeY_3(pipeY_3), .pipeY_4(pipeY_4),
    .collision(collision), .hit_pulse(hit_pulse), .hit_type(hit_type),
    .hit_pipe(hit_pipe), .check_done(check_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected first hit for the current scenario, straight from the game rules
  function automatic void refEval(output bit hit, output logic [1:0] ty, output logic [1:0] pp);
    longint bx, by, px, py;
    bx = mBX;
    by = mBY;
    hit = 1'b0;
    ty  = 2'd0;
    pp  = 2'd0;
    if (by + 24 >= 420) begin
      hit = 1'b1; ty = 2'd2;
    end else if (by < 0) begin
      hit = 1'b1; ty = 2'd3;
    end else begin
      for (int i = 0; i < 4; i++) begin
        px = mPX[i];
        py = mPY[i];
        if (!hit && bx + 34 > px && bx < px + 78 && (by < py || by + 24 > py + 128)) begin
          hit = 1'b1; ty = 2'd1; pp = 2'(i);
        end
      end
    end
  endfunction

  task automatic clearModel();
    mCol = 1'b0; mType = 2'd0; mPipe = 2'd0;
  endtask

  task automatic setGs(input logic [3:0] g);
    game_state = g;
    if (g == GS_START) clearModel();
  endtask

  task automatic applyInputs();
    birdX = mBX; birdY = mBY;
    pipeX_1 = mPX[0]; pipeX_2 = mPX[1]; pipeX_3 = mPX[2]; pipeX_4 = mPX[3];
    pipeY_1 = mPY[0]; pipeY_2 = mPY[1]; pipeY_3 = mPY[2]; pipeY_4 = mPY[3];
  endtask

  // Move the live inputs after the snapshot; the result must not follow them
  task automatic scrambleInputs();
    birdX = $urandom_range(450);
    birdY = 32'(int'($urandom_range(480)) - 40);
    pipeX_1 = $urandom_range(600); pipeX_2 = $urandom_range(600);
    pipeX_3 = $urandom_range(600); pipeX_4 = $urandom_range(600);
    pipeY_1 = $urandom_range(320); pipeY_2 = $urandom_range(320);
    pipeY_3 = $urandom_range(320); pipeY_4 = $urandom_range(320);
  endtask

  task automatic setScene(input int bx, input int by, input int px0, input int py0,
                          input int px1, input int px2, input int px3);
    mBX = bx; mBY = by;
    mPX[0] = px0; mPX[1] = px1; mPX[2] = px2; mPX[3] = px3;
    for (int i = 0; i < 4; i++) mPY[i] = py0;
  endtask

  // One FL_clk rise; optional abort (game_state change) or rst pulse at cycle c
  task automatic frame(input int abortAt, input logic [3:0] abortGs, input int rstAt,
                       input bit scramble);
    int doneAt, doneCnt, pulseCnt;
    bit hit, expDone, expPulse;
    logic [1:0] t, p;
    doneAt = -1; doneCnt = 0; pulseCnt = 0; expPulse = 1'b0;
    expDone = (abortAt == 0 && rstAt == 0 && game_state == GS_IN);
    applyInputs();
    if (expDone) begin
      refEval(hit, t, p);
      if (hit && !mCol) begin
        expPulse = 1'b1; mCol = 1'b1; mType = t; mPipe = p;
      end
    end
    FL_clk = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      if (check_done) begin
        doneCnt++;
        if (doneAt < 0) doneAt = c;
      end
      if (hit_pulse) pulseCnt++;
      if (c == 3) FL_clk = 1'b0;
      if (c == 6 && scramble) scrambleInputs();
      if (c == abortAt) game_state = abortGs;
      if (rstAt != 0 && c == rstAt) rst = 1'b1;
      if (rstAt != 0 && c == rstAt + 1) rst = 1'b0;
    end
    if (rstAt != 0) clearModel();
    chk("done_count", doneCnt, expDone);
    if (expDone) chk("done_latency", doneAt, 10);
    chk("pulse_count", pulseCnt, expPulse);
    chk("collision", collision, mCol);
    chk("hit_type", hit_type, mType);
    chk("hit_pipe", hit_pipe, mPipe);
  endtask

  task automatic startClear();
    setGs(GS_START);
    repeat (2) @(posedge clk);
    #1;
    chk("clear_collision", collision, 1'b0);
    chk("clear_hit_type", hit_type, 2'd0);
    setGs(GS_IN);
  endtask

  initial begin
    int r;
    rst = 1'b1; FL_clk = 1'b0; game_state = GS_START;
    clearModel();
    setScene(0, 0, 0, 0, 0, 0, 0);
    applyInputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_collision", collision, 1'b0);
    chk("rst_hit_pulse", hit_pulse, 1'b0);
    chk("rst_hit_type", hit_type, 2'd0);
    chk("rst_hit_pipe", hit_pipe, 2'd0);
    chk("rst_check_done", check_done, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    setGs(GS_IN);

    // Clear flight through pipe 0's gap, then the same with bird above the gap
    setScene(100, 200, 80, 150, 900, 900, 900);
    frame(0, GS_IN, 0, 1'b0);
    setScene(100, 140, 80, 150, 900, 900, 900);
    frame(0, GS_IN, 0, 1'b0);

    // Floor beats an overlapping pipe 2; a repeat frame gives no second pulse
    startClear();
    setScene(100, 400, 900, 150, 900, 80, 900);
    frame(0, GS_IN, 0, 1'b0);
    frame(0, GS_IN, 0, 1'b0);

    // Touching x edges are not a hit; one pixel of overlap is
    startClear();
    setScene(100, 140, 900, 150, 134, 900, 900);
    frame(0, GS_IN, 0, 1'b0);
    setScene(100, 140, 900, 150, 133, 900, 900);
    frame(0, GS_IN, 0, 1'b0);

    // Ceiling and exact-floor-touch boundaries
    startClear();
    setScene(100, -1, 900, 150, 900, 900, 900);
    frame(0, GS_IN, 0, 1'b0);
    startClear();
    setScene(100, 395, 900, 150, 900, 900, 900);
    frame(0, GS_IN, 0, 1'b0);
    startClear();
    setScene(100, 396, 900, 150, 900, 900, 900);
    frame(0, GS_IN, 0, 1'b0);

    // Pause mid-scan aborts silently; pause holds a latched hit; start clears it
    startClear();
    setScene(100, 140, 80, 150, 900, 900, 900);
    frame(7, GS_PAUSE, 0, 1'b0);
    setGs(GS_IN);
    frame(0, GS_IN, 0, 1'b0);
    setGs(GS_PAUSE);
    frame(0, GS_IN, 0, 1'b0);
    startClear();

    // Reset mid-scan after a latched hit, then a frame edge on the start screen
    frame(0, GS_IN, 0, 1'b0);
    frame(0, GS_IN, 7, 1'b0);
    setGs(GS_START);
    frame(0, GS_IN, 0, 1'b0);
    setGs(GS_IN);

    // Randomized frames with clears, aborts, edge-aligned pipes and mid-scan updates
    for (int n = 0; n < 40; n++) begin
      mBX = $urandom_range(450);
      mBY = int'($urandom_range(480)) - 40;
      for (int i = 0; i < 4; i++) begin
        mPX[i] = $urandom_range(600);
        mPY[i] = $urandom_range(320);
      end
      if ($urandom_range(3) == 0) mPX[$urandom_range(3)] = mBX + 34 - int'($urandom_range(1));
      if ($urandom_range(3) == 0) mPX[$urandom_range(3)] = mBX - 78 + int'($urandom_range(1));
      r = $urandom_range(9);
      if (r < 3) startClear();
      if (r == 3) begin
        frame(int'($urandom_range(4, 9)), ($urandom_range(1) == 0) ? GS_PAUSE : GS_END, 0, 1'b0);
        setGs(GS_IN);
      end else begin
        frame(0, GS_IN, 0, 1'($urandom_range(1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
